micro_decoder: RTL and testbench

- Downstream consumer of the 30-bit microinstruction register (MIR) produced by the control store.
- Latches each new microinstruction and splits it into fields.
- Issues per-phase datapath controls over a 4-phase micro-cycle, and runs the memory request/acknowledge handshake.
- Drives stall back to the control store's enable path while memory is busy, and reports halt and error status.

---
 rtl/micro_decoder.sv | 171 +++++++++++++++++
 tb/tb_micro_decoder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_decoder.sv
// Microinstruction decoder: latches the 30-bit MIR, splits it into fields and
// sequences a 4-phase micro-cycle with a memory request/acknowledge handshake.
module micro_decoder #(
    parameter int MIR_W       = 30,
    parameter int NREG        = 10,
    parameter int MEM_TIMEOUT = 15,
    parameter int UCOUNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [MIR_W-1:0]    mir,
    input  logic                finish,
    input  logic                mem_ack,
    output logic [7:0]          next_addr,
    output logic [3:0]          alu_op,
    output logic [NREG-1:0]     reg_we,
    output logic                mem_req,
    output logic                mem_we,
    output logic                mdr_load,
    output logic                pc_inc,
    output logic [3:0]          bus_sel,
    output logic [1:0]          phase,
    output logic                stall,
    output logic                halted,
    output logic                mem_err,
    output logic [UCOUNT_W-1:0] ucount
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEMWAIT, S_HALT} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           phase_reg, phase_next;
    logic [MIR_W-1:0]     mir_reg, mir_next;
    logic [7:0]           next_addr_reg, next_addr_next;
    logic [UCOUNT_W-1:0]  ucount_reg, ucount_next;
    logic                 halted_reg, halted_next;
    logic                 mem_err_reg, mem_err_next;
    logic                 halt_pend_reg, halt_pend_next;
    logic [WCNT_W-1:0]    wait_cnt_reg, wait_cnt_next;

    // Field views of the latched microinstruction
    logic [7:0]      f_next_addr;
    logic [3:0]      f_alu;
    logic [NREG-1:0] f_we;
    logic            f_rd, f_mdr, f_wr, f_pc;
    logic [3:0]      f_bus;
    logic            in_wb;

    assign f_next_addr = mir_reg[29:22];
    assign f_alu       = mir_reg[21:18];
    assign f_we        = mir_reg[8+NREG-1:8];
    assign f_rd        = mir_reg[7];
    assign f_mdr       = mir_reg[6];
    assign f_wr        = mir_reg[5];
    assign f_pc        = mir_reg[4];
    assign f_bus       = mir_reg[3:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            phase_reg     <= 2'd0;
            mir_reg       <= '0;
            next_addr_reg <= '0;
            ucount_reg    <= '0;
            halted_reg    <= 1'b0;
            mem_err_reg   <= 1'b0;
            halt_pend_reg <= 1'b0;
            wait_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            mir_reg       <= mir_next;
            next_addr_reg <= next_addr_next;
            ucount_reg    <= ucount_next;
            halted_reg    <= halted_next;
            mem_err_reg   <= mem_err_next;
            halt_pend_reg <= halt_pend_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        mir_next       = mir_reg;
        next_addr_next = next_addr_reg;
        ucount_next    = ucount_reg;
        halted_next    = halted_reg;
        mem_err_next   = mem_err_reg;
        halt_pend_next = halt_pend_reg;
        wait_cnt_next  = wait_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (enable) begin
                    state_next     = S_RUN;
                    phase_next     = 2'd0;
                    mir_next       = mir;
                    halt_pend_next = finish;
                end
            end
            S_RUN: begin
                if (finish) halt_pend_next = 1'b1;
                case (phase_reg)
                    2'd0: phase_next = 2'd1;
                    2'd1: begin
                        if (f_rd || f_wr) begin
                            state_next    = S_MEMWAIT;
                            wait_cnt_next = '0;
                        end else begin
                            phase_next = 2'd2;
                        end
                    end
                    2'd2: phase_next = 2'd3;
                    default: begin
                        next_addr_next = f_next_addr;
                        ucount_next    = ucount_reg + 1'b1;
                        phase_next     = 2'd0;
                        // A finish seen anywhere in this micro-cycle wins over enable
                        if (halt_pend_reg || finish) begin
                            state_next  = S_HALT;
                            halted_next = 1'b1;
                        end else if (enable) begin
                            mir_next = mir;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end
                endcase
            end
            S_MEMWAIT: begin
                if (finish) halt_pend_next = 1'b1;
                if (mem_ack) begin
                    state_next = S_RUN;
                    phase_next = 2'd2;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Give up on memory but still retire the instruction
                    state_next   = S_RUN;
                    phase_next   = 2'd2;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign in_wb = (state_reg == S_RUN) && (phase_reg == 2'd2);

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg_we
        assign reg_we[gi] = in_wb & f_we[gi];
    end

    assign mdr_load  = in_wb & f_mdr;
    assign pc_inc    = in_wb & f_pc;
    assign mem_req   = (state_reg == S_MEMWAIT);
    assign mem_we    = mem_req & f_wr;
    assign stall     = mem_req;
    assign alu_op    = f_alu;
    assign bus_sel   = f_bus;
    assign phase     = phase_reg;
    assign next_addr = next_addr_reg;
    assign ucount    = ucount_reg;
    assign halted    = halted_reg;
    assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_micro_decoder.sv
// Self-checking bench for micro_decoder: vector table through a scoreboard,
// plus hand-written halt, async-reset-in-wait and ucount-wrap sequences.
module tb_micro_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [29:0] mir;
    logic        finish;
    logic        mem_ack = 1'b0;
    logic [7:0]  next_addr;
    logic [3:0]  alu_op;
    logic [9:0]  reg_we;
    logic        mem_req, mem_we, mdr_load, pc_inc;
    logic [3:0]  bus_sel;
    logic [1:0]  phase;
    logic        stall, halted, mem_err;
    logic [15:0] ucount;

    // Narrow-counter instance used only to exercise the wrap in few cycles
    logic        enable_w;
    logic [29:0] mir_w;
    logic        finish_w, mem_ack_w;
    logic [7:0]  next_addr_w;
    logic [3:0]  alu_op_w, bus_sel_w;
    logic [9:0]  reg_we_w;
    logic        mem_req_w, mem_we_w, mdr_load_w, pc_inc_w;
    logic [1:0]  phase_w;
    logic        stall_w, halted_w, mem_err_w;
    logic [3:0]  ucount_w;

    always #5 clk = ~clk;

    micro_decoder #(.MIR_W(30), .NREG(10), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mir(mir), .finish(finish),
        .mem_ack(mem_ack), .next_addr(next_addr), .alu_op(alu_op), .reg_we(reg_we),
        .mem_req(mem_req), .mem_we(mem_we), .mdr_load(mdr_load), .pc_inc(pc_inc),
        .bus_sel(bus_sel), .phase(phase), .stall(stall), .halted(halted),
        .mem_err(mem_err), .ucount(ucount)
    );

    micro_decoder #(.MIR_W(30), .NREG(10), .MEM_TIMEOUT(15), .UCOUNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .enable(enable_w), .mir(mir_w), .finish(finish_w),
        .mem_ack(mem_ack_w), .next_addr(next_addr_w), .alu_op(alu_op_w), .reg_we(reg_we_w),
        .mem_req(mem_req_w), .mem_we(mem_we_w), .mdr_load(mdr_load_w), .pc_inc(pc_inc_w),
        .bus_sel(bus_sel_w), .phase(phase_w), .stall(stall_w), .halted(halted_w),
        .mem_err(mem_err_w), .ucount(ucount_w)
    );

    typedef struct {
        logic [29:0] mir;
        int          ack_dly;   // 0 = never acknowledge
        logic [9:0]  we;
        logic [3:0]  alu;
        logic [3:0]  bus;
        logic        mdr;
        logic        pc;
        logic        wr;
        int          wait_n;    // expected cycles with mem_req high
        logic        err;       // expected mem_err at write-back
    } vec_t;

    typedef struct {
        vec_t        v;
        logic [7:0]  na;
        logic [15:0] ucnt;
    } sb_t;

    localparam int NV = 8;
    vec_t vecs [NV];
    sb_t  sb_q [$];
    sb_t  post_e;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_dly = 0;
    int resp_n  = 0;
    int ucnt_model = 0;
    int cyc = 0;
    int last_wb = -1;
    int mreq_n = 0;
    int stall_n = 0;
    int post_n = 0;
    int stray_n = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp_v);
        end
    endtask

    task automatic check_reset();
        check("rst_next_addr", 32'(next_addr), 32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_reg_we",    32'(reg_we),    32'd0);
        check("rst_mem_req",   32'(mem_req),   32'd0);
        check("rst_mem_we",    32'(mem_we),    32'd0);
        check("rst_mdr_load",  32'(mdr_load),  32'd0);
        check("rst_pc_inc",    32'(pc_inc),    32'd0);
        check("rst_bus_sel",   32'(bus_sel),   32'd0);
        check("rst_phase",     32'(phase),     32'd0);
        check("rst_stall",     32'(stall),     32'd0);
        check("rst_halted",    32'(halted),    32'd0);
        check("rst_mem_err",   32'(mem_err),   32'd0);
        check("rst_ucount",    32'(ucount),    32'd0);
    endtask

    function automatic logic [29:0] mk_mir(input logic [7:0] na, input logic [3:0] alu,
                                           input logic [9:0] we, input logic rd, input logic mdr,
                                           input logic wr, input logic pc, input logic [3:0] bus);
        return {na, alu, we, rd, mdr, wr, pc, bus};
    endfunction

    task automatic apply(input vec_t v);
        sb_t e;
        mir     = v.mir;
        ack_dly = v.ack_dly;
        ucnt_model++;
        e.v    = v;
        e.na   = v.mir[29:22];
        e.ucnt = 16'(ucnt_model);
        sb_q.push_back(e);
    endtask

    task automatic wait_phase(input logic [1:0] p, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (phase !== p && n < 100);
        check(nm, 32'(phase), 32'(p));
    endtask

    // Memory model: acknowledge in the ack_dly-th cycle of mem_req
    always @(negedge clk) begin
        if (mem_req) begin
            resp_n++;
            mem_ack = (ack_dly != 0) && (resp_n == ack_dly);
        end else begin
            resp_n  = 0;
            mem_ack = 1'b0;
        end
    end

    // Monitor: pops the scoreboard at every write-back phase
    always @(negedge clk) begin
        sb_t e;
        cyc++;
        if (!rst_n) begin
            mreq_n  = 0;
            stall_n = 0;
            post_n  = 0;
            last_wb = -1;
        end else begin
            if (post_n > 0) begin
                post_n--;
                if (post_n == 0) begin
                    check("next_addr", 32'(next_addr), 32'(post_e.na));
                    check("ucount",    32'(ucount),    32'(post_e.ucnt));
                end
            end
            if (mem_req) begin
                mreq_n++;
                check("memwait_phase", 32'(phase), 32'd1);
                if (sb_q.size() > 0) check("mem_we", 32'(mem_we), 32'(sb_q[0].v.wr));
            end
            if (stall) stall_n++;
            if (phase == 2'd2) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_wb", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    $display("[TB] wb mir=%h reg_we=%h alu=%h bus=%h mdr=%b pc=%b waits=%0d err=%b",
                             e.v.mir, reg_we, alu_op, bus_sel, mdr_load, pc_inc, mreq_n, mem_err);
                    check("reg_we",    32'(reg_we),   32'(e.v.we));
                    check("alu_op",    32'(alu_op),   32'(e.v.alu));
                    check("bus_sel",   32'(bus_sel),  32'(e.v.bus));
                    check("mdr_load",  32'(mdr_load), 32'(e.v.mdr));
                    check("pc_inc",    32'(pc_inc),   32'(e.v.pc));
                    check("mem_err",   32'(mem_err),  32'(e.v.err));
                    check("req_cycles", 32'(mreq_n),  32'(e.v.wait_n));
                    check("stall_cycles", 32'(stall_n), 32'(e.v.wait_n));
                    if (last_wb >= 0) check("cycle_len", 32'(cyc - last_wb), 32'(4 + e.v.wait_n));
                    last_wb = cyc;
                    mreq_n  = 0;
                    stall_n = 0;
                    post_e  = e;
                    post_n  = 2;
                end
            end else if (reg_we != '0 || mdr_load || pc_inc) begin
                stray_n++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        int   n;
        int   pulses;

        //          mir                                                   ack  we      alu   bus   mdr pc wr  wait err
        vecs[0] = '{mk_mir(8'h01, 4'h4, 10'h001, 0, 0, 0, 0, 4'h1),  0, 10'h001, 4'h4, 4'h1, 0, 0, 0,  0, 0};
        vecs[1] = '{mk_mir(8'h12, 4'h2, 10'h000, 1, 1, 0, 0, 4'h3),  3, 10'h000, 4'h2, 4'h3, 1, 0, 0,  3, 0};
        vecs[2] = '{mk_mir(8'hFF, 4'hF, 10'h3FF, 0, 0, 0, 1, 4'hF),  0, 10'h3FF, 4'hF, 4'hF, 0, 1, 0,  0, 0};
        vecs[3] = '{mk_mir(8'h80, 4'h9, 10'h200, 0, 0, 1, 0, 4'h5),  1, 10'h200, 4'h9, 4'h5, 0, 0, 1,  1, 0};
        vecs[4] = '{mk_mir(8'h55, 4'hA, 10'h0AA, 1, 1, 1, 1, 4'hA),  2, 10'h0AA, 4'hA, 4'hA, 1, 1, 1,  2, 0};
        vecs[5] = '{mk_mir(8'h3C, 4'h6, 10'h00F, 0, 0, 1, 0, 4'h2),  0, 10'h00F, 4'h6, 4'h2, 0, 0, 1, 15, 1};
        vecs[6] = '{mk_mir(8'h00, 4'h0, 10'h000, 0, 0, 0, 0, 4'h0),  0, 10'h000, 4'h0, 4'h0, 0, 0, 0,  0, 1};
        vecs[7] = '{mk_mir(8'hA5, 4'h1, 10'h3C3, 0, 1, 0, 0, 4'h8),  0, 10'h3C3, 4'h1, 4'h8, 1, 0, 0,  0, 1};
        hv      = '{mk_mir(8'h77, 4'h3, 10'h155, 0, 0, 0, 1, 4'h6),  0, 10'h155, 4'h3, 4'h6, 0, 1, 0,  0, 1};

        rst_n = 1'b0; enable = 1'b0; finish = 1'b0; mir = '0;
        enable_w = 1'b0; mir_w = '0; finish_w = 1'b0; mem_ack_w = 1'b0;
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_phase", 32'(phase), 32'd0);

        // Back-to-back table through the scoreboard
        apply(vecs[0]);
        enable = 1'b1;
        for (int i = 1; i < NV; i++) begin
            wait_phase(2'd3, "seq_phase3");
            apply(vecs[i]);
        end

        // Halt: finish raised during phase 1 of the last instruction
        wait_phase(2'd3, "seq_phase3");
        apply(hv);
        wait_phase(2'd1, "halt_phase1");
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!halted && n < 12);
        check("halted_set", 32'(halted), 32'd1);
        check("halt_phase", 32'(phase), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5)  enable = 1'b0;
            if (i == 10) enable = 1'b1;
            @(negedge clk);
            if (reg_we != '0 || mdr_load || pc_inc) pulses++;
        end
        check("halt_no_pulses", 32'(pulses), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_ucount", 32'(ucount), 32'd9);

        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        // Async reset while waiting on memory that never answers
        mir = mk_mir(8'hC3, 4'h7, 10'h3FF, 1, 1, 0, 1, 4'hE);
        ack_dly = 0;
        enable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 20);
        check("memwait_entry", 32'(mem_req), 32'd1);
        repeat (3) @(negedge clk);
        check("stall_in_wait", 32'(stall), 32'd1);
        check("alu_in_wait", 32'(alu_op), 32'h7);
        enable = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(mem_req), 32'd0);
        check("post_rst_phase", 32'(phase), 32'd0);

        // Counter wrap on the narrow instance: 16 retirements return it to 0
        enable_w = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (phase_w != 2'd3 && n < 20);
            @(negedge clk);
            check("ucount_wrap", 32'(ucount_w), 32'(i % 16));
        end
        enable_w = 1'b0;

        check("stray_pulses", 32'(stray_n), 32'd0);
        check("sb_final", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
